// File: rtl/ysyx_23060072_sim_pkg.sv
// Shared definitions for the simulation controller.
// The state encoding is fixed so the debug port reads HOLD=0, RUN=1, DONE=2.
// The ebreak instruction word ends a run.
package ysyx_23060072_sim_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sim_state_e;

  localparam logic [31:0] EBREAK_INST = 32'h00100073;

  // Wide enough for any legal reset-hold length (1..255).
  localparam int HOLD_W = 8;

endpackage

// File: rtl/ysyx_23060072_lane_scan.sv
// Combinational scan of the commit lanes.
// It finds the oldest (lowest-index) valid lane that carries ebreak.
// It also builds the mask of lanes whose retirement counts.
//   valid      : per-lane retire strobe, lane 0 oldest
//   inst       : per-lane instruction words, 32 bits each
//   ebreak_hit : some valid lane holds ebreak
//   ebreak_idx : index of the first such lane (0 when none)
//   count_mask : valid lanes up to and including that lane, else all valid lanes
module ysyx_23060072_lane_scan
  import ysyx_23060072_sim_pkg::*;
#(
  parameter int NCOMMIT = 1,
  parameter int IDX_W   = 1
) (
  input  logic [NCOMMIT-1:0]    valid,
  input  logic [NCOMMIT*32-1:0] inst,
  output logic                  ebreak_hit,
  output logic [IDX_W-1:0]      ebreak_idx,
  output logic [NCOMMIT-1:0]    count_mask
);

  logic found;

  // Lanes are examined oldest first. Once an ebreak has been seen,
  // every younger lane is dropped from the mask.
  always_comb begin
    found      = 1'b0;
    ebreak_idx = '0;
    count_mask = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      if (!found) begin
        count_mask[i] = valid[i];
        if (valid[i] && (inst[i*32 +: 32] == EBREAK_INST)) begin
          found      = 1'b1;
          ebreak_idx = IDX_W'(i);
        end
      end
    end
    ebreak_hit = found;
  end

endmodule

// File: rtl/ysyx_23060072_sim_ctrl.sv
// Simulation controller.
// It holds the core in reset for RST_CYCLES clocks and then counts cycles and
// retired instructions. It ends the run on the first ebreak. With the optional
// watchdog, it also ends the run after TIMEOUT RUN cycles.
// Optional feature macro: YSYX_23060072_WATCHDOG_EN. When it is undefined,
// timeout is tied to 0 and only ebreak ends the run.
// Ports:
//   clk, rst_n             : clock and async active-low reset
//   core_rst_n             : registered active-low reset to the core
//   commit_valid/inst/a0   : per-lane retire information, lane 0 oldest
//   state                  : FSM state (HOLD=0, RUN=1, DONE=2)
//   done, pass, timeout    : run outcome, frozen once in DONE
//   cycle_cnt, instret_cnt : saturating RUN-cycle and retire counters
module ysyx_23060072_sim_ctrl
  import ysyx_23060072_sim_pkg::*;
#(
  parameter int          NCOMMIT    = 1,
  parameter int          XLEN       = 32,
  parameter int          CNT_W      = 32,
  parameter int          RST_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 125
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    core_rst_n,
  input  logic [NCOMMIT-1:0]      commit_valid,
  input  logic [NCOMMIT*32-1:0]   commit_inst,
  input  logic [NCOMMIT*XLEN-1:0] commit_a0,
  output logic [1:0]              state,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [CNT_W-1:0]        cycle_cnt,
  output logic [CNT_W-1:0]        instret_cnt
);

  localparam int IDX_W = (NCOMMIT > 1) ? $clog2(NCOMMIT) : 1;
  localparam int POP_W = $clog2(NCOMMIT + 1);

  // Elaboration-time guards on the legal parameter ranges.
  if (NCOMMIT < 1 || NCOMMIT > 4) begin : g_bad_ncommit
    $error("NCOMMIT must be 1..4");
  end
  if (RST_CYCLES < 1 || RST_CYCLES > 255) begin : g_bad_rst_cycles
    $error("RST_CYCLES must be 1..255");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  logic               ebreak_hit;
  logic [IDX_W-1:0]   ebreak_idx;
  logic [NCOMMIT-1:0] count_mask;

  ysyx_23060072_lane_scan #(
    .NCOMMIT (NCOMMIT),
    .IDX_W   (IDX_W)
  ) u_lane_scan (
    .valid      (commit_valid),
    .inst       (commit_inst),
    .ebreak_hit (ebreak_hit),
    .ebreak_idx (ebreak_idx),
    .count_mask (count_mask)
  );

  logic [POP_W-1:0] pop;
  logic [XLEN-1:0]  hit_a0;

  always_comb begin
    pop    = '0;
    hit_a0 = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      pop = pop + POP_W'(count_mask[i]);
      if (ebreak_idx == IDX_W'(i)) hit_a0 = commit_a0[i*XLEN +: XLEN];
    end
  end

  sim_state_e        state_q,       state_d;
  logic [HOLD_W-1:0] hold_cnt_q,    hold_cnt_d;
  logic              core_rst_n_q,  core_rst_n_d;
  logic              done_q,        done_d;
  logic              pass_q,        pass_d;
  logic [CNT_W-1:0]  cycle_cnt_q,   cycle_cnt_d;
  logic [CNT_W-1:0]  instret_cnt_q, instret_cnt_d;
`ifdef YSYX_23060072_WATCHDOG_EN
  logic              timeout_q,     timeout_d;
`endif

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    core_rst_n_d  = core_rst_n_q;
    done_d        = done_q;
    pass_d        = pass_q;
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
`ifdef YSYX_23060072_WATCHDOG_EN
    timeout_d     = timeout_q;
`endif
    case (state_q)
      HOLD: begin
        // The edge that enters RUN also releases the core reset.
        if (hold_cnt_q == HOLD_W'(RST_CYCLES - 1)) begin
          state_d      = RUN;
          core_rst_n_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      RUN: begin
        // The terminating cycle itself is still counted.
        cycle_cnt_d   = sat_add(cycle_cnt_q, CNT_W'(1));
        instret_cnt_d = sat_add(instret_cnt_q, CNT_W'(pop));
        if (ebreak_hit) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (hit_a0 == '0);
        end
`ifdef YSYX_23060072_WATCHDOG_EN
        else if (cycle_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = DONE;
          done_d    = 1'b1;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
        end
`endif
      end
      DONE: ;
      default: begin
        // The unused encoding is treated as a failed run.
        state_d      = DONE;
        done_d       = 1'b1;
        pass_d       = 1'b0;
        core_rst_n_d = 1'b1;
`ifdef YSYX_23060072_WATCHDOG_EN
        timeout_d    = 1'b1;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HOLD;
      hold_cnt_q    <= '0;
      core_rst_n_q  <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
`ifdef YSYX_23060072_WATCHDOG_EN
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      core_rst_n_q  <= core_rst_n_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
`ifdef YSYX_23060072_WATCHDOG_EN
      timeout_q     <= timeout_d;
`endif
    end
  end

  assign state       = state_q;
  assign core_rst_n  = core_rst_n_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`ifdef YSYX_23060072_WATCHDOG_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: doc/ysyx_23060072_sim_ctrl.md
YSYX_23060072_SIM_CTRL -- requirements
Module: ysyx_23060072_sim_ctrl

Interface
REQ-001 SHALL provide parameter NCOMMIT, default 1, number of commit lanes (legal range 1..4).
REQ-002 SHALL provide parameter XLEN, default 32, width of the per-lane a0 value.
REQ-003 SHALL provide parameter CNT_W, default 32, width of the cycle and instret counters.
REQ-004 SHALL provide parameter RST_CYCLES, default 4, number of cycles the core is held in reset (legal range 1..255).
REQ-005 SHALL provide parameter TIMEOUT, default 125, watchdog limit in RUN cycles (legal range 1..2^CNT_W-1).
REQ-006 SHALL have port clk, input, 1: the single clock.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have port core_rst_n, output, 1: sequenced active-low reset to the core.
REQ-009 SHALL have port commit_valid, input, NCOMMIT: per-lane retire strobe; lane 0 is oldest.
REQ-010 SHALL have port commit_inst, input, NCOMMIT*32: per-lane retired instruction word.
REQ-011 SHALL have port commit_a0, input, NCOMMIT*XLEN: per-lane value of x10 at retire.
REQ-012 SHALL have port state, output, 2: encoded FSM state.
REQ-013 SHALL have port done, output, 1: run finished.
REQ-014 SHALL have port pass, output, 1: run finished by ebreak with a0==0.
REQ-015 SHALL have port timeout, output, 1: run finished by watchdog.
REQ-016 SHALL have port cycle_cnt, output, CNT_W: count of RUN cycles.
REQ-017 SHALL have port instret_cnt, output, CNT_W: count of retired instructions.

Function
REQ-018 SHALL implement three states, HOLD=0, RUN=1 and DONE=2, and SHALL never enter encoding 3; if encoding 3 occurs it SHALL go to DONE with timeout=1.
REQ-019 In HOLD, core_rst_n SHALL be 0. An internal counter SHALL count RST_CYCLES clocks, then go to RUN. core_rst_n SHALL be registered and rise on the clock edge that enters RUN.
REQ-020 In RUN, cycle_cnt SHALL increment by 1 every cycle.
REQ-021 In RUN, instret_cnt SHALL increment by the popcount of the counted lanes.
REQ-022 Both counters SHALL saturate at all-ones rather than wrap.
REQ-023 The ebreak encoding is 32'h00100073. The lowest-index lane with valid=1 and inst==ebreak SHALL terminate the run.
REQ-024 On termination, only lanes up to and including the ebreak lane SHALL be counted, and lanes above it SHALL be ignored.
REQ-025 On ebreak termination, the FSM SHALL go to DONE on the next edge with pass=(that lane's a0==0), timeout=0 and done=1.
REQ-026 Watchdog: if the RUN cycle in which cycle_cnt==TIMEOUT-1 has no ebreak, the FSM SHALL go to DONE with timeout=1 and pass=0. If ebreak and timeout coincide, ebreak SHALL win.
REQ-027 In DONE, the counters, pass and timeout SHALL be frozen, core_rst_n SHALL remain 1, and all commit inputs SHALL be ignored.
REQ-028 Latency: done SHALL assert exactly one clock after the terminating cycle.
REQ-029 Inputs SHALL be ignored in HOLD.

Reset
REQ-030 rst_n low SHALL immediately force state=HOLD, core_rst_n=0, done=0, pass=0, timeout=0, cycle_cnt=0, instret_cnt=0 and the hold counter=0, including mid-RUN or in DONE.
REQ-031 After rst_n rises, the block SHALL repeat the full RST_CYCLES hold sequence.

Configuration
REQ-032 With macro YSYX_23060072_WATCHDOG_EN defined, REQ-026 SHALL apply.
REQ-033 Without YSYX_23060072_WATCHDOG_EN, the timeout output SHALL be tied to 0, no watchdog compare logic SHALL exist, and the run SHALL end only on ebreak.

Structure
REQ-034 Package ysyx_23060072_sim_pkg SHALL hold the state enum (HOLD/RUN/DONE) and the constant EBREAK_INST=32'h00100073.
REQ-035 Sub-module ysyx_23060072_lane_scan SHALL be combinational. It SHALL take the valid and inst vectors and output ebreak_hit, ebreak_idx and count_mask (a lane mask up to and including the first ebreak, else all valid lanes).

Verification
REQ-036 Reset sequence: rst_n low for 100 ns, then released with RST_CYCLES=4 -> core_rst_n low for exactly 4 clocks, then high; state HOLD->RUN.
REQ-037 Pass case: NCOMMIT=1, 10 valid non-ebreak commits, then ebreak with a0=0 -> next edge done=1, pass=1, timeout=0, instret_cnt=11.
REQ-038 Fail case: ebreak with a0=32'h1 -> done=1 and pass=0.
REQ-039 Multi-lane: NCOMMIT=4, valid=4'b1111, lane1=ebreak with a0=0 -> instret_cnt increases by 2, not 4; pass=1.
REQ-040 Watchdog: TIMEOUT=125 with no ebreak -> done=1, timeout=1 one clock after cycle_cnt==124. The same stimulus with ebreak on that cycle -> pass=1, timeout=0. With the macro undefined -> still running at cycle 200.
REQ-041 Mid-run reset: assert rst_n at cycle 50 of RUN -> all outputs return to their REQ-030 values in the same cycle, and the hold sequence repeats after release.
REQ-042 Saturation: CNT_W=4 with TIMEOUT disabled and 20 commits -> instret_cnt holds at 4'hF.
